// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared write-back widths, bus field offsets and counter-inhibit bit indices
package riscv_pkg;
  localparam int WB_BUS_W  = 70;
  localparam int FWD_BUS_W = 38;
  localparam int TRACE_W   = 70;

  // Write-back bus, MSB first: {rd[4:0], rd_wen, wb_data[31:0], pc[31:0]}
  localparam int WB_PC_LSB   = 0;
  localparam int WB_DATA_LSB = 32;
  localparam int WB_WEN_BIT  = 64;
  localparam int WB_RD_LSB   = 65;

  localparam int CNT_INH_CYCLE   = 0;
  localparam int CNT_INH_INSTRET = 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] wb_data;
    logic [31:0] pc;
  } wb_bus_t;

  function automatic wb_bus_t unpack_wb_bus(input logic [WB_BUS_W-1:0] raw);
    wb_bus_t b;
    b.rd      = raw[WB_RD_LSB +: 5];
    b.rd_wen  = raw[WB_WEN_BIT];
    b.wb_data = raw[WB_DATA_LSB +: 32];
    b.pc      = raw[WB_PC_LSB +: 32];
    return b;
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-to-write-back bus with valid/allowin handshake
interface wb_stage_if;
  import riscv_pkg::*;

  logic [WB_BUS_W-1:0] mem_wb_bus_in;
  logic                mem_exception;
  logic                ms_to_ws_valid;
  logic                ws_allowin;

  modport master (
    output mem_wb_bus_in,
    output mem_exception,
    output ms_to_ws_valid,
    input  ws_allowin
  );

  modport slave (
    input  mem_wb_bus_in,
    input  mem_exception,
    input  ms_to_ws_valid,
    output ws_allowin
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - commit-trace FIFO, registered full/empty; instantiated only under WB_TRACE_FIFO_EN
module wb_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             full_r, empty_r;
  logic             push, pop;

  assign push = s_tvalid && !full_r;
  assign pop  = m_tready && !empty_r;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so the upstream stall never sees a comb path from m_tready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      full_r  <= (count_nxt == FULL_CNT);
      empty_r <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  assign s_tready = !full_r;
  assign m_tvalid = !empty_r;
  assign m_tdata  = empty_r ? '0 : mem[rd_ptr];
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: bus latch, regfile port, forwarding, cycle/instret counters
// Commit-trace FIFO and its backpressure are built only when WB_TRACE_FIFO_EN is defined.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_stage_if.slave            ms,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [FWD_BUS_W-1:0] ws_fwd_bus,
  input  logic [1:0]           cnt_inhibit,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [TRACE_W-1:0]   trace_data
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_bus_t bus_r;
  logic    ws_valid, killed_r;
  logic    ws_ready_go, ws_allowin, retire, fifo_full, wb_ok;

  assign ws_ready_go   = !fifo_full;
  assign ws_allowin    = !ws_valid || ws_ready_go;
  assign ms.ws_allowin = ws_allowin;
  assign retire        = ws_valid && ws_ready_go;

  // Killed entries and x0 targets still retire but never touch the regfile or the bypass
  assign wb_ok      = bus_r.rd_wen && !killed_r && (bus_r.rd != 5'd0);
  assign rf_we      = retire && wb_ok;
  assign rf_waddr   = bus_r.rd;
  assign rf_wdata   = bus_r.wb_data;
  assign ws_fwd_bus = {bus_r.rd, ws_valid && wb_ok, bus_r.wb_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_valid <= 1'b0;
      bus_r    <= '0;
      killed_r <= 1'b0;
    end else begin
      if (ws_allowin) ws_valid <= ms.ms_to_ws_valid;
      if (ws_allowin && ms.ms_to_ws_valid) begin
        bus_r    <= unpack_wb_bus(ms.mem_wb_bus_in);
        killed_r <= ms.mem_exception;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (!cnt_inhibit[CNT_INH_CYCLE]) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (retire && !killed_r && !cnt_inhibit[CNT_INH_INSTRET])
        instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

`ifdef WB_TRACE_FIFO_EN
  logic fifo_s_tready;

  wb_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_W)
  ) u_trace_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  ({bus_r.pc, bus_r.rd, bus_r.rd_wen, bus_r.wb_data}),
    .s_tvalid (retire && !killed_r),
    .s_tready (fifo_s_tready),
    .m_tdata  (trace_data),
    .m_tvalid (trace_valid),
    .m_tready (trace_ready)
  );

  assign fifo_full = !fifo_s_tready;
`else
  logic unused_trace;

  assign fifo_full    = 1'b0;
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
  assign unused_trace = ^{trace_ready, bus_r.pc, TRACE_DEPTH > 1};
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector table and scoreboard bench for wb_stage; trace checks follow WB_TRACE_FIFO_EN
module tb_wb_stage;
  import riscv_pkg::*;

`ifdef WB_TRACE_FIFO_EN
  localparam int HOLD_AT  = 4;
  localparam bit TRACE_ON = 1'b1;
`else
  localparam int HOLD_AT  = 99;
  localparam bit TRACE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cnt_inhibit;
  logic        trace_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] ws_fwd_bus;
  logic [63:0] cycle_cnt, instret_cnt;
  logic        trace_valid;
  logic [69:0] trace_data;

  logic [3:0]  cycle4, instret4;
  logic        unused4_we, unused4_tv;
  logic [4:0]  unused4_waddr;
  logic [31:0] unused4_wdata;
  logic [37:0] unused4_fwd;
  logic [69:0] unused4_td;

  wb_stage_if ms_if();
  wb_stage_if ms4_if();

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ms(ms_if),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_bus(ws_fwd_bus),
    .cnt_inhibit(cnt_inhibit), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data)
  );

  // Narrow-counter instance exercises the modulo-2^CNT_W wrap
  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ms(ms4_if),
    .rf_we(unused4_we), .rf_waddr(unused4_waddr), .rf_wdata(unused4_wdata), .ws_fwd_bus(unused4_fwd),
    .cnt_inhibit(cnt_inhibit), .cycle_cnt(cycle4), .instret_cnt(instret4),
    .trace_valid(unused4_tv), .trace_ready(1'b1), .trace_data(unused4_td)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[6];
  logic [36:0] rf_q[$];
  logic [69:0] tq[$];
  int          checks = 0;
  int          failures = 0;
  longint      cyc_exp = 0;
  longint      exp_instret = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!cnt_inhibit[CNT_INH_CYCLE]) cyc_exp++;
  endtask

  task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] data,
                      input logic [31:0] pc, input logic exc, input logic exp_we, input logic counted);
    ms_if.mem_wb_bus_in  = {rd, wen, data, pc};
    ms_if.mem_exception  = exc;
    ms_if.ms_to_ws_valid = 1'b1;
    if (counted) begin
      if (exp_we) rf_q.push_back({rd, data});
      if (!exc) begin
        tq.push_back({pc, rd, wen, data});
        if (!cnt_inhibit[CNT_INH_INSTRET]) exp_instret++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      if (rf_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rf_unexpected: got write rd=%0d data=%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        check("rf_sb", {33'd0, rf_waddr, rf_wdata}, {33'd0, rf_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (tq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trace_unexpected: got %0h expected no entry", trace_data);
      end else begin
        check("trace_sb", trace_data, tq.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{5'd5,  1'b1, 32'hDEADBEEF, 32'h8000_0010, 1'b0, 1'b1};
    vecs[1] = '{5'd0,  1'b1, 32'h1234_5678, 32'h8000_0014, 1'b0, 1'b0};
    vecs[2] = '{5'd7,  1'b1, 32'hCAFE_0007, 32'h8000_0018, 1'b1, 1'b0};
    vecs[3] = '{5'd31, 1'b0, 32'h5555_AAAA, 32'h8000_001C, 1'b0, 1'b0};
    vecs[4] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 32'h8000_0020, 1'b0, 1'b1};
    vecs[5] = '{5'd1,  1'b1, 32'h0000_0000, 32'h8000_0024, 1'b0, 1'b1};

    rst_n = 1'b1;
    cnt_inhibit = 2'b00;
    trace_ready = 1'b1;
    ms_if.mem_wb_bus_in = '0;  ms_if.mem_exception = 1'b0;  ms_if.ms_to_ws_valid = 1'b0;
    ms4_if.mem_wb_bus_in = '0; ms4_if.mem_exception = 1'b0; ms4_if.ms_to_ws_valid = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();

    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_fwd", ws_fwd_bus, 0);
    check("rst_allowin", ms_if.ws_allowin, 1);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_instret", instret_cnt, 0);
    check("rst_trace_valid", trace_valid, 0);
    check("rst_trace_data", trace_data, 0);
    rst_n = 1'b1;
    cyc_exp = 0;
    exp_instret = 0;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].rd, vecs[i].wen, vecs[i].data, vecs[i].pc, vecs[i].exc, vecs[i].exp_we, 1'b1);
      step();
      ms_if.ms_to_ws_valid = 1'b0;
      check("vec_rf_we", rf_we, vecs[i].exp_we);
      check("vec_waddr", rf_waddr, vecs[i].rd);
      check("vec_wdata", rf_wdata, vecs[i].data);
      check("vec_fwd", ws_fwd_bus, {vecs[i].rd, vecs[i].exp_we, vecs[i].data});
      check("vec_allowin", ms_if.ws_allowin, 1);
      step();
      check("vec_rf_we_after", rf_we, 0);
      check("vec_fwd_after", ws_fwd_bus, {vecs[i].rd, 1'b0, vecs[i].data});
      check("vec_instret", instret_cnt, exp_instret);
      check("vec_cycle", cycle_cnt, cyc_exp);
      check("vec_trace_valid", trace_valid, TRACE_ON && !vecs[i].exc);
    end

    // Back-to-back burst with the trace consumer stalled
    step();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(5'(10 + i), 1'b1, 32'h1000 + i, 32'h8000_0100 + 4 * i, 1'b0, 1'b1, 1'b1);
      step();
      check("burst_rf_we", rf_we, (i == HOLD_AT) ? 0 : 1);
      check("burst_allowin", ms_if.ws_allowin, (i == HOLD_AT) ? 0 : 1);
    end
    ms_if.ms_to_ws_valid = 1'b0;
`ifdef WB_TRACE_FIFO_EN
    step();
    step();
    check("hold_allowin", ms_if.ws_allowin, 0);
    check("hold_rf_we", rf_we, 0);
    check("hold_fwd_wen", ws_fwd_bus[32], 1);
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    check("release_rf_we", rf_we, 1);
    check("release_waddr", rf_waddr, 14);
    check("release_allowin", ms_if.ws_allowin, 1);
    step();
    check("refill_trace_valid", trace_valid, 1);
    trace_ready = 1'b1;
    repeat (5) step();
    check("drain_empty", trace_valid, 0);
    check("drain_queue", tq.size(), 0);
`else
    step();
    check("burst_last_rf_we", rf_we, 0);
    check("burst_trace_valid", trace_valid, 0);
    trace_ready = 1'b1;
`endif
    check("burst_instret", instret_cnt, exp_instret);

    // Counter inhibit: both frozen, then cycle only
    cnt_inhibit = 2'b11;
    send(5'd3, 1'b1, 32'hAAAA_5555, 32'h8000_0200, 1'b0, 1'b1, 1'b1);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    repeat (9) step();
    check("inh_cycle", cycle_cnt, cyc_exp);
    check("inh_instret", instret_cnt, exp_instret);
    cnt_inhibit = 2'b01;
    send(5'd4, 1'b1, 32'h0000_0044, 32'h8000_0204, 1'b0, 1'b1, 1'b1);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    repeat (2) step();
    check("inh0_cycle", cycle_cnt, cyc_exp);
    check("inh0_instret", instret_cnt, exp_instret);
    cnt_inhibit = 2'b00;

    for (int k = 0; k < 16 && cyc_exp[3:0] != 4'hF; k++) step();
    check("wrap_pre", cycle4, 4'hF);
    step();
    check("wrap_zero", cycle4, 0);
    check("wrap_instret4", instret4, 0);
    check("wide_cycle", cycle_cnt, cyc_exp);

    // Asynchronous reset with three trace entries queued and one held in the stage
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(5'(20 + i), 1'b1, 32'h2000 + i, 32'h8000_0300 + 4 * i, 1'b0, 1'b1, i < 3);
      step();
    end
    ms_if.ms_to_ws_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rf_we", rf_we, 0);
    check("mid_rst_waddr", rf_waddr, 0);
    check("mid_rst_fwd", ws_fwd_bus, 0);
    check("mid_rst_allowin", ms_if.ws_allowin, 1);
    check("mid_rst_cycle", cycle_cnt, 0);
    check("mid_rst_instret", instret_cnt, 0);
    check("mid_rst_trace_valid", trace_valid, 0);
    check("mid_rst_trace_data", trace_data, 0);
    tq.delete();
    step();
    step();
    rst_n = 1'b1;
    cyc_exp = 0;
    exp_instret = 0;
    trace_ready = 1'b1;
    step();
    check("post_rst_trace_valid", trace_valid, 0);
    check("post_rst_cycle", cycle_cnt, 1);

    send(5'd9, 1'b1, 32'h0BAD_F00D, 32'h8000_0400, 1'b0, 1'b1, 1'b1);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    check("recover_rf_we", rf_we, 1);
    repeat (3) step();
    check("recover_instret", instret_cnt, exp_instret);
    check("rf_queue_empty", rf_q.size(), 0);
`ifdef WB_TRACE_FIFO_EN
    check("trace_queue_empty", tq.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Final (write-back) stage of the 5-stage RISC-V pipeline, directly downstream of the memory stage. It latches the 70-bit memory/write-back bus under the valid/allowin handshake and drives the integer register-file write port and a forwarding bus for hazard resolution. It also maintains the 64-bit cycle and instret counters, and optionally records every retired instruction into a commit-trace FIFO for the debug/trace port.

## Interface
Parameters:
- TRACE_DEPTH, 4: commit-trace FIFO entries; power of two, ≥2; used only when the trace feature is compiled in.
- CNT_W, 64: width of the cycle and instret counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_wb_bus_in  in  70  {rd[4:0], rd_wen, wb_data[31:0], pc[31:0]}, MSB first.
- mem_exception  in  1  memory stage's exception flag (exception_stalled), sampled with the bus.
- ms_to_ws_valid  in  1  bus holds a valid instruction.
- ws_allowin  out  1  stage can accept a bus this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- ws_fwd_bus  out  38  {rd, fwd_wen, wb_data}, for decode-stage bypass.
- cnt_inhibit  in  2  [0] freezes cycle; [1] freezes instret.
- cycle_cnt  out  CNT_W  cycles since reset.
- instret_cnt  out  CNT_W  retired, non-killed instructions.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer pops head when trace_valid && trace_ready.
- trace_data  out  70  {pc, rd, rd_wen, wb_data} of the FIFO head.

## Operation
- Pipeline register: ws_valid, bus_r, killed_r. On ws_allowin=1: ws_valid <= ms_to_ws_valid. When ws_allowin && ms_to_ws_valid: bus_r <= mem_wb_bus_in and killed_r <= mem_exception.
- ws_ready_go = !fifo_full (registered state, no same-cycle pop bypass). ws_allowin = !ws_valid || ws_ready_go.
- Retire event: ws_valid && ws_ready_go. Each entry retires exactly once.
- rf_we = retire && rd_wen_r && !killed_r && rd_r != 0; rf_waddr = rd_r; rf_wdata = wb_data_r.
- ws_fwd_bus: fwd_wen = ws_valid && rd_wen_r && !killed_r && rd_r != 0. It stays asserted while the entry is held by backpressure.
- cycle_cnt increments every cycle unless cnt_inhibit[0] is set.
- instret_cnt increments on retire && !killed_r unless cnt_inhibit[1] is set.
- Both counters wrap modulo 2^CNT_W with no saturation.
- Trace FIFO: push on retire && !killed_r; pop on trace_valid && trace_ready. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo TRACE_DEPTH. A pop while empty is ignored.

## Timing
- Reset values: ws_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, ws_fwd_bus=0, ws_allowin=1, cycle_cnt=0, instret_cnt=0, FIFO empty, trace_valid=0, trace_data=0.
- Latency: bus captured at edge N; rf_we is high during cycle N+1 and the regfile writes at edge N+1.
- The trace entry becomes visible on trace_valid one cycle after the retire edge.
- Backpressure: when the FIFO is full, the entry holds, rf_we stays 0, and ws_allowin=0 until the first edge after a pop.
- Reset asserted mid-operation: all state clears asynchronously and the held entry is discarded without writing the regfile.

## Configuration
- WB_TRACE_FIFO_EN defined: the commit-trace FIFO and its backpressure are built as described above.
- WB_TRACE_FIFO_EN undefined:
  - No FIFO is built and ws_ready_go=1, so ws_allowin is always 1.
  - trace_valid=0 and trace_data=0; trace_ready is ignored.
  - Every valid entry retires in the cycle after capture.

## Structure
- Shared package riscv_pkg holds:
  - WB_BUS_W=70, FWD_BUS_W=38, TRACE_W=70.
  - Field offsets of the write-back bus.
  - The counter-inhibit bit indices.
- Sub-module: wb_trace_fifo (parameterised depth/width, valid/ready on both sides, registered full/empty), instantiated only under WB_TRACE_FIFO_EN.

## Test plan
- Reset, then bus {rd=5, wen=1, data=0xDEADBEEF, pc=0x80000010} with valid for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; instret_cnt=1.
- Bus with rd=0, wen=1 -> rf_we=0 and fwd_wen=0; instret_cnt still increments.
- Valid bus with mem_exception=1 -> rf_we=0, instret_cnt unchanged, no trace push.
- Trace on, trace_ready=0, 5 back-to-back instructions -> 4 entries retire, 5th held with ws_allowin=0 and rf_we=0. Raising trace_ready for one cycle -> 5th retires on the following edge. The FIFO returns pcs in order.
- cnt_inhibit=2'b11 for 10 cycles -> both counters frozen. Preload cycle_cnt near 2^64-1 via forced state -> wraps to 0.
- Assert rst_n=0 mid-stream with FIFO at 3 entries -> all outputs at reset values immediately, FIFO empty after release.
